// File: rtl/ov7670_mode_cfg_if.sv
// Write-request handshake between the mode configurator and the SCCB write master.
// The master side raises wr_valid with a stable address and data until sccb_done pulses.
interface ov7670_mode_cfg_if;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       sccb_done;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  sccb_done
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output sccb_done
   );
endinterface

// File: rtl/ov7670_mode_cfg.sv
// Rewrites the OV7670 format registers whenever the requested rgb/test mode changes,
// and publishes the applied mode only after the sensor has had time to settle.
module ov7670_mode_cfg #(
   parameter int C_SETTLE_CYC  = 1_000_000,
   parameter int C_TIMEOUT_CYC = 2_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rgbmode,
   input  logic                      testmode,
   ov7670_mode_cfg_if.master         sccb,
   output logic                      cfg_busy,
   output logic                      cfg_err,
   output logic                      rgbmode_app,
   output logic                      testmode_app
);

   localparam int SET_W = (C_SETTLE_CYC  > 1) ? $clog2(C_SETTLE_CYC)  : 1;
   localparam int TMO_W = (C_TIMEOUT_CYC > 1) ? $clog2(C_TIMEOUT_CYC) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(C_SETTLE_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_NEXT,
      S_SETTLE
   } state_t;

   state_t           state_reg;
   logic             init_reg;
   logic             rgb_l_reg;
   logic             tst_l_reg;
   logic [1:0]       idx_reg;
   logic [SET_W-1:0] set_cnt_reg;
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             mode_chg;

   assign mode_chg = ({rgbmode, testmode} != {rgb_l_reg, tst_l_reg});

   function automatic logic [7:0] reg_addr(input logic [1:0] idx);
      case (idx)
         2'd0:    reg_addr = 8'h12;
         2'd1:    reg_addr = 8'h40;
         2'd2:    reg_addr = 8'h70;
         default: reg_addr = 8'h71;
      endcase
   endfunction

   function automatic logic [7:0] reg_data(input logic [1:0] idx, input logic rgb, input logic tst);
      case (idx)
         2'd0:    reg_data = {5'b0, rgb, tst, 1'b0};
         2'd1:    reg_data = rgb ? 8'hD0 : 8'hC0;
         2'd2:    reg_data = {tst, 7'h3A};
         default: reg_data = {tst, 7'h35};
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         init_reg      <= 1'b1;
         rgb_l_reg     <= 1'b1;
         tst_l_reg     <= 1'b0;
         idx_reg       <= 2'd0;
         set_cnt_reg   <= '0;
         tmo_cnt_reg   <= '0;
         sccb.wr_valid <= 1'b0;
         sccb.wr_addr  <= 8'h00;
         sccb.wr_data  <= 8'h00;
         cfg_busy      <= 1'b0;
         cfg_err       <= 1'b0;
         rgbmode_app   <= 1'b1;
         testmode_app  <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (init_reg || mode_chg)
                  state_reg <= S_LOAD;
            end

            // Table entry 0 is built from the live inputs since the latch updates on this same edge.
            S_LOAD: begin
               rgb_l_reg     <= rgbmode;
               tst_l_reg     <= testmode;
               idx_reg       <= 2'd0;
               init_reg      <= 1'b0;
               cfg_busy      <= 1'b1;
               sccb.wr_valid <= 1'b1;
               sccb.wr_addr  <= reg_addr(2'd0);
               sccb.wr_data  <= reg_data(2'd0, rgbmode, testmode);
               tmo_cnt_reg   <= '0;
               state_reg     <= S_REQ;
            end

            // Done wins over a timeout expiring on the same cycle.
            S_REQ: begin
               if (sccb.sccb_done) begin
                  sccb.wr_valid <= 1'b0;
                  state_reg     <= S_NEXT;
               end else if (tmo_cnt_reg == TMO_LAST) begin
                  sccb.wr_valid <= 1'b0;
                  cfg_err       <= 1'b1;
                  state_reg     <= S_LOAD;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end

            S_NEXT: begin
               if (mode_chg) begin
                  state_reg <= S_LOAD;
               end else if (idx_reg == 2'd3) begin
                  set_cnt_reg <= '0;
                  state_reg   <= S_SETTLE;
               end else begin
                  idx_reg       <= idx_reg + 2'd1;
                  sccb.wr_valid <= 1'b1;
                  sccb.wr_addr  <= reg_addr(idx_reg + 2'd1);
                  sccb.wr_data  <= reg_data(idx_reg + 2'd1, rgb_l_reg, tst_l_reg);
                  tmo_cnt_reg   <= '0;
                  state_reg     <= S_REQ;
               end
            end

            S_SETTLE: begin
               if (mode_chg) begin
                  state_reg <= S_LOAD;
               end else if (set_cnt_reg == SET_LAST) begin
                  rgbmode_app  <= rgb_l_reg;
                  testmode_app <= tst_l_reg;
                  cfg_busy     <= 1'b0;
                  cfg_err      <= 1'b0;
                  state_reg    <= S_IDLE;
               end else begin
                  set_cnt_reg <= set_cnt_reg + 1'b1;
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_mode_cfg.sv
// Directed bench for ov7670_mode_cfg: SCCB responder model, write log and
// settle/timeout scenarios with short parameter values.
module tb_ov7670_mode_cfg;

   localparam int SETTLE  = 20;
   localparam int TIMEOUT = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rgbmode = 1'b1;
   logic testmode = 1'b0;
   logic cfg_busy, cfg_err, rgbmode_app, testmode_app;

   ov7670_mode_cfg_if bus ();

   ov7670_mode_cfg #(
      .C_SETTLE_CYC  (SETTLE),
      .C_TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rgbmode      (rgbmode),
      .testmode     (testmode),
      .sccb         (bus.master),
      .cfg_busy     (cfg_busy),
      .cfg_err      (cfg_err),
      .rgbmode_app  (rgbmode_app),
      .testmode_app (testmode_app)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // SCCB responder: done about 5 cycles after valid, or a forced stray pulse.
   logic done_en = 1'b1;
   logic pulse_req = 1'b0;
   int   resp_cnt = 0;
   initial begin
      bus.sccb_done = 1'b0;
      forever begin
         @(negedge clk);
         if (pulse_req) begin
            bus.sccb_done = 1'b1;
            pulse_req = 1'b0;
         end else if (bus.sccb_done) begin
            bus.sccb_done = 1'b0;
            resp_cnt = 0;
         end else if (done_en && bus.wr_valid) begin
            if (resp_cnt == 4) bus.sccb_done = 1'b1;
            else resp_cnt++;
         end else begin
            resp_cnt = 0;
         end
      end
   end

   // Write log {addr,data} at each wr_valid rise, and count cfg_busy falls.
   logic [15:0] log_q[$];
   int   busy_falls = 0;
   logic prev_valid = 1'b0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (bus.wr_valid && !prev_valid) log_q.push_back({bus.wr_addr, bus.wr_data});
      if (!cfg_busy && prev_busy) busy_falls = busy_falls + 1;
      prev_valid = bus.wr_valid;
      prev_busy = cfg_busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_write(input logic [7:0] a, input string tag);
      int n = 0;
      while (!(bus.wr_valid && bus.wr_addr == a) && n < 500) begin
         tick(1);
         n++;
      end
      check(tag, 32'(n < 500), 32'd1);
   endtask

   task automatic wait_busy_fall(input string tag);
      int start = busy_falls;
      int n = 0;
      while (busy_falls == start && n < 2000) begin
         tick(1);
         n++;
      end
      check(tag, 32'(n < 2000), 32'd1);
   endtask

   task automatic check_log(input string tag, input logic [15:0] exp[$]);
      check({tag, "_len"}, 32'(log_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         check($sformatf("%s_w%0d", tag, i), 32'(log_q[i]), 32'(exp[i]));
   endtask

   initial begin
      int n;
      int falls0;

      // Reset state
      tick(3);
      check("rst_valid", 32'(bus.wr_valid), 32'd0);
      check("rst_addr",  32'(bus.wr_addr), 32'h00);
      check("rst_data",  32'(bus.wr_data), 32'h00);
      check("rst_busy",  32'(cfg_busy), 32'd0);
      check("rst_err",   32'(cfg_err), 32'd0);
      check("rst_app",   32'({rgbmode_app, testmode_app}), 32'b10);

      // 1: init sequence after release
      @(negedge clk);
      rst = 1'b0;
      tick(1);
      check("t1_valid_lo", 32'(bus.wr_valid), 32'd0);
      tick(1);
      check("t1_valid_hi", 32'(bus.wr_valid), 32'd1);
      check("t1_first",    32'({bus.wr_addr, bus.wr_data}), 32'h1204);
      check("t1_busy",     32'(cfg_busy), 32'd1);
      wait_busy_fall("t1_done");
      check_log("t1_log", '{16'h1204, 16'h40D0, 16'h703A, 16'h7135});
      check("t1_app", 32'({rgbmode_app, testmode_app}), 32'b10);
      check("t1_err", 32'(cfg_err), 32'd0);

      // 2: mode change from idle
      tick(3);
      log_q = {};
      rgbmode = 1'b0;
      testmode = 1'b1;
      tick(1);
      check("t2_valid_lo", 32'(bus.wr_valid), 32'd0);
      tick(1);
      check("t2_valid_hi", 32'(bus.wr_valid), 32'd1);
      check("t2_first",    32'({bus.wr_addr, bus.wr_data}), 32'h1202);
      falls0 = busy_falls;
      wait_busy_fall("t2_done");
      check_log("t2_log", '{16'h1202, 16'h40C0, 16'h70BA, 16'h71B5});
      check("t2_app", 32'({rgbmode_app, testmode_app}), 32'b01);

      // 3: change while idx1 is in flight
      tick(3);
      log_q = {};
      rgbmode = 1'b1;
      testmode = 1'b0;
      wait_write(8'h40, "t3_reach_idx1");
      testmode = 1'b1;
      falls0 = busy_falls;
      check("t3_app_mid", 32'({rgbmode_app, testmode_app}), 32'b01);
      wait_busy_fall("t3_done");
      tick(SETTLE + 10);
      check("t3_one_update", 32'(busy_falls - falls0), 32'd1);
      check_log("t3_log", '{16'h1204, 16'h40D0, 16'h1206, 16'h40D0, 16'h70BA, 16'h71B5});
      check("t3_app", 32'({rgbmode_app, testmode_app}), 32'b11);

      // 4: timeout with no done, then recovery
      log_q = {};
      done_en = 1'b0;
      rgbmode = 1'b0;
      testmode = 1'b0;
      wait_write(8'h12, "t4_reach_com7");
      n = 0;
      while (bus.wr_valid && n < 200) begin
         n++;
         tick(1);
      end
      check("t4_valid_cycles", 32'(n), 32'(TIMEOUT));
      check("t4_err_set", 32'(cfg_err), 32'd1);
      check("t4_busy", 32'(cfg_busy), 32'd1);
      tick(1);
      check("t4_rewrite", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'h11200);
      done_en = 1'b1;
      wait_busy_fall("t4_done");
      check("t4_err_clr", 32'(cfg_err), 32'd0);
      check_log("t4_log", '{16'h1200, 16'h1200, 16'h40C0, 16'h703A, 16'h7135});
      check("t4_app", 32'({rgbmode_app, testmode_app}), 32'b00);

      // 5: reset during idx2
      tick(3);
      rgbmode = 1'b1;
      testmode = 1'b0;
      wait_write(8'h70, "t5_reach_idx2");
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_valid", 32'(bus.wr_valid), 32'd0);
      check("t5_rst_app", 32'({rgbmode_app, testmode_app}), 32'b10);
      check("t5_rst_busy", 32'(cfg_busy), 32'd0);
      tick(3);
      log_q = {};
      @(negedge clk);
      rst = 1'b0;
      wait_busy_fall("t5_done");
      check_log("t5_log", '{16'h1204, 16'h40D0, 16'h703A, 16'h7135});
      check("t5_app", 32'({rgbmode_app, testmode_app}), 32'b10);

      // 6: stray done in IDLE and in SETTLE
      tick(3);
      log_q = {};
      pulse_req = 1'b1;
      tick(4);
      check("t6_idle_valid", 32'(bus.wr_valid), 32'd0);
      check("t6_idle_busy", 32'(cfg_busy), 32'd0);
      check("t6_idle_log", 32'(log_q.size()), 32'd0);
      check("t6_idle_app", 32'({rgbmode_app, testmode_app}), 32'b10);
      rgbmode = 1'b0;
      testmode = 1'b1;
      wait_write(8'h71, "t6_reach_idx3");
      n = 0;
      while (bus.wr_valid && n < 100) begin
         n++;
         tick(1);
      end
      tick(2);
      pulse_req = 1'b1;
      tick(4);
      check("t6_settle_valid", 32'(bus.wr_valid), 32'd0);
      check("t6_settle_busy", 32'(cfg_busy), 32'd1);
      check("t6_settle_app", 32'({rgbmode_app, testmode_app}), 32'b10);
      wait_busy_fall("t6_done");
      check_log("t6_log", '{16'h1202, 16'h40C0, 16'h70BA, 16'h71B5});
      check("t6_app", 32'({rgbmode_app, testmode_app}), 32'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
